// File: rtl/y86_fetch_pc.sv
// Sequential-Y86 fetch stage: byte-addressed instruction memory, combinational decode at the
// architectural PC, next-PC selection and machine-status tracking (RUN until a non-AOK fetch).
module y86_fetch_pc #(
  parameter int IMEM_BYTES = 1024,
  parameter int AW         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          run_en,
  input  logic          cnd,
  input  logic [63:0]   valM,
  output logic [3:0]    icode,
  output logic [3:0]    ifun,
  output logic [3:0]    rA,
  output logic [3:0]    rB,
  output logic [63:0]   valC,
  output logic [63:0]   valP,
  output logic [63:0]   pc,
  output logic [2:0]    stat,
  output logic          halted,
  output logic [31:0]   instr_count
);

  // state   | meaning
  // S_RUN   | fetching; a PC update on each run_en edge
  // S_HALTED| frozen on a non-AOK status until reset
  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          pc_hi_q, pc_hi_d;
  logic [2:0]    stat_q, stat_d;
  logic [31:0]   cnt_q, cnt_d;

  logic [7:0]    mem_q [IMEM_BYTES];
  logic [7:0]    fb [10];
  logic          ins;
  logic          adr;
  logic [3:0]    len;
  logic [2:0]    dstat;
  logic [63:0]   pc_ext;
  logic [63:0]   npc;

  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end

  // Fetch window wraps modulo the memory size.
  always_comb begin
    for (int i = 0; i < 10; i++) fb[i] = mem_q[pc_q + AW'(i)];
  end

  assign pc_ext = {{(64-AW){1'b0}}, pc_q};

  always_comb begin
    icode = fb[0][7:4];
    ifun  = fb[0][3:0];
    ins   = 1'b0;
    case (icode)
      4'h2, 4'h7:                      ins = (ifun > 4'd6);
      4'h6:                            ins = (ifun > 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
      4'h8, 4'h9, 4'hA, 4'hB:          ins = (ifun != 4'd0);
      default:                         ins = 1'b1;
    endcase

    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      4'h7, 4'h8:             len = 4'd9;
      default:                len = 4'd1;
    endcase
    if (ins) len = 4'd1;

    rA   = 4'hF;
    rB   = 4'hF;
    valC = 64'd0;
    if (!ins) begin
      case (icode)
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: begin
          rA = fb[1][7:4];
          rB = fb[1][3:0];
        end
        default: ;
      endcase
      case (icode)
        4'h3, 4'h4, 4'h5: valC = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
        4'h7, 4'h8:       valC = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
        default: ;
      endcase
    end

    valP = pc_ext + {60'd0, len};
    adr  = pc_hi_q || ((valP - 64'd1) >= 64'(IMEM_BYTES));

    if (ins)                dstat = ST_INS;
    else if (adr)           dstat = ST_ADR;
    else if (icode == 4'h0) dstat = ST_HLT;
    else                    dstat = ST_AOK;
  end

  always_comb begin
    npc = valP;
    case (icode)
      4'h7:    if (cnd) npc = valC;
      4'h8:    npc = valC;
      4'h9:    npc = valM;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_hi_d = pc_hi_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    if (state_q == S_RUN && run_en) begin
      if (dstat == ST_AOK) begin
        pc_d    = npc[AW-1:0];
        pc_hi_d = |npc[63:AW];
        cnt_d   = cnt_q + 32'd1;
      end else begin
        stat_d  = dstat;
        state_d = S_HALTED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      pc_hi_q <= 1'b0;
      stat_q  <= ST_AOK;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_hi_q <= pc_hi_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_ext;
  assign halted      = (state_q == S_HALTED);
  assign stat        = (state_q == S_RUN) ? dstat : stat_q;
  assign instr_count = cnt_q;

endmodule
